// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent prescaled up-counters with compare match, periodic/one-shot mode and sticky interrupts
// Ports: axi_clk/rst_n clock and async active-low reset; enable/clear/one_shot/irq_en/irq_clear per-channel controls;
// prescaler/compare packed per channel; counter/match_pulse/irq_status/done per-channel state; irq combined interrupt.
module timer_bank #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 32,
    parameter int PSC_WIDTH = 16
) (
    input  logic                        axi_clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           enable,
    input  logic [NUM_CH-1:0]           clear,
    input  logic [NUM_CH-1:0]           one_shot,
    input  logic [NUM_CH*PSC_WIDTH-1:0] prescaler,
    input  logic [NUM_CH*WIDTH-1:0]     compare,
    input  logic [NUM_CH-1:0]           irq_en,
    input  logic [NUM_CH-1:0]           irq_clear,
    output logic [NUM_CH*WIDTH-1:0]     counter,
    output logic [NUM_CH-1:0]           match_pulse,
    output logic [NUM_CH-1:0]           irq_status,
    output logic [NUM_CH-1:0]           done,
    output logic                        irq
);
    logic [WIDTH-1:0]     cnt_q [NUM_CH];
    logic [PSC_WIDTH-1:0] psc_q [NUM_CH];
    logic [NUM_CH-1:0]    done_q, mp_q, sts_q, run, tick, hit;

    always_comb begin
        run  = '0;
        tick = '0;
        hit  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            run[n]  = enable[n] & ~clear[n] & ~done_q[n];
            // >= so a prescaler lowered below the running count ticks immediately
            tick[n] = run[n] && (psc_q[n] >= prescaler[n*PSC_WIDTH +: PSC_WIDTH]);
            hit[n]  = tick[n] && (cnt_q[n] == compare[n*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n] <= '0;
                psc_q[n] <= '0;
            end
            done_q <= '0;
            mp_q   <= '0;
            sts_q  <= '0;
        end else begin
            mp_q  <= hit;
            // set wins over a simultaneous clear strobe
            sts_q <= (sts_q & ~irq_clear) | hit;
            for (int n = 0; n < NUM_CH; n++) begin
                if (clear[n]) begin
                    cnt_q[n]  <= '0;
                    psc_q[n]  <= '0;
                    done_q[n] <= 1'b0;
                end else if (run[n]) begin
                    psc_q[n] <= tick[n] ? '0 : psc_q[n] + 1'b1;
                    if (hit[n]) begin
                        cnt_q[n]  <= one_shot[n] ? cnt_q[n] : '0;
                        done_q[n] <= one_shot[n];
                    end else if (tick[n]) begin
                        cnt_q[n] <= cnt_q[n] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_cnt
        assign counter[n*WIDTH +: WIDTH] = cnt_q[n];
    end

    assign match_pulse = mp_q;
    assign irq_status  = sts_q;
    assign done        = done_q;
    assign irq         = |(sts_q & irq_en);
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed plus randomized stimulus for timer_bank checked against a cycle-level behavioural model
module tb_timer_bank;
    localparam int NC = 4;
    localparam int W  = 8;
    localparam int PW = 4;

    logic              axi_clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     enable, clear, one_shot, irq_en, irq_clear;
    logic [NC*PW-1:0]  prescaler;
    logic [NC*W-1:0]   compare;
    logic [NC*W-1:0]   counter;
    logic [NC-1:0]     match_pulse, irq_status, done;
    logic              irq;

    int tests = 0;
    int fails = 0;
    int m_cnt [NC];
    int m_psc [NC];
    logic [NC-1:0] m_mp, m_sts, m_done;

    timer_bank #(.NUM_CH(NC), .WIDTH(W), .PSC_WIDTH(PW)) dut (
        .axi_clk(axi_clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .one_shot(one_shot), .prescaler(prescaler), .compare(compare),
        .irq_en(irq_en), .irq_clear(irq_clear), .counter(counter),
        .match_pulse(match_pulse), .irq_status(irq_status), .done(done), .irq(irq)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NC; n++) begin
            m_cnt[n] = 0;
            m_psc[n] = 0;
        end
        m_mp = '0; m_sts = '0; m_done = '0;
    endtask

    // One clock edge of the timer rules, in plain integer arithmetic
    task automatic model_edge();
        for (int n = 0; n < NC; n++) begin
            int  p = int'(prescaler[n*PW +: PW]);
            int  c = int'(compare[n*W +: W]);
            logic h = 1'b0;
            if (clear[n]) begin
                m_cnt[n] = 0; m_psc[n] = 0; m_done[n] = 1'b0;
            end else if (!m_done[n] && enable[n]) begin
                if (m_psc[n] >= p) begin
                    m_psc[n] = 0;
                    if (m_cnt[n] == c) begin
                        h = 1'b1;
                        if (one_shot[n]) m_done[n] = 1'b1;
                        else m_cnt[n] = 0;
                    end else begin
                        m_cnt[n] = (m_cnt[n] + 1) % (1 << W);
                    end
                end else begin
                    m_psc[n]++;
                end
            end
            m_mp[n]  = h;
            m_sts[n] = h | (m_sts[n] & ~irq_clear[n]);
        end
    endtask

    task automatic check_all();
        for (int n = 0; n < NC; n++)
            chk($sformatf("counter%0d", n), 32'(counter[n*W +: W]), 32'(m_cnt[n]));
        chk("match_pulse", 32'(match_pulse), 32'(m_mp));
        chk("irq_status", 32'(irq_status), 32'(m_sts));
        chk("done", 32'(done), 32'(m_done));
        chk("irq", 32'(irq), 32'(|(m_sts & irq_en)));
    endtask

    task automatic step();
        @(posedge axi_clk);
        if (!rst_n) model_reset(); else model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int k;
        enable = '0; clear = '0; one_shot = '0; irq_en = '0; irq_clear = '0;
        prescaler = '0; compare = '0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all();
        step();
        step();
        @(negedge axi_clk) rst_n = 1'b1;

        // ch0 periodic P0 C3, ch1 one-shot P2 C2, ch2 periodic P9 C3, ch3 periodic P0 C255
        one_shot = 4'b0010;
        prescaler[0*PW +: PW] = 4'd0; compare[0*W +: W] = 8'd3;
        prescaler[1*PW +: PW] = 4'd2; compare[1*W +: W] = 8'd2;
        prescaler[2*PW +: PW] = 4'd9; compare[2*W +: W] = 8'd3;
        prescaler[3*PW +: PW] = 4'd0; compare[3*W +: W] = 8'hFF;
        irq_en = 4'b0001;
        clear = '1; enable = '1;
        step();
        clear = '0;
        repeat (9) step();
        chk("ch0_cnt_after9", 32'(counter[0*W +: W]), 32'd1);
        chk("ch1_cnt_after9", 32'(counter[1*W +: W]), 32'd2);
        chk("ch1_done_after9", 32'(done[1]), 32'd1);
        chk("ch2_cnt_after9", 32'(counter[2*W +: W]), 32'd0);
        chk("ch0_sts_first", 32'(irq_status[0]), 32'd1);
        chk("irq_masked_on", 32'(irq), 32'd1);

        enable[2] = 1'b0;
        repeat (5) step();
        chk("ch2_frozen", 32'(counter[2*W +: W]), 32'd0);
        chk("ch1_still_frozen", 32'(counter[1*W +: W]), 32'd2);
        enable[2] = 1'b1;
        step();
        chk("ch2_tick_after_pause", 32'(counter[2*W +: W]), 32'd1);

        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        chk("ch1_cleared_cnt", 32'(counter[1*W +: W]), 32'd0);
        chk("ch1_cleared_done", 32'(done[1]), 32'd0);

        // irq_clear coinciding with a match leaves the flag set
        k = 0;
        while (k < 8 && !match_pulse[0]) begin step(); k++; end
        chk("ch0_match_found", 32'(match_pulse[0]), 32'd1);
        repeat (3) step();
        irq_clear[0] = 1'b1;
        step();
        chk("ch0_match_with_clr", 32'(match_pulse[0]), 32'd1);
        chk("sts_set_wins", 32'(irq_status[0]), 32'd1);
        step();
        chk("sts_cleared", 32'(irq_status[0]), 32'd0);
        chk("irq_dropped", 32'(irq), 32'd0);
        irq_clear[0] = 1'b0;

        // ch3 full-range period, then compare lowered below the running count
        k = 0;
        while (k < 300 && !match_pulse[3]) begin step(); k++; end
        chk("ch3_ff_match", 32'(match_pulse[3]), 32'd1);
        chk("ch3_ff_reload", 32'(counter[3*W +: W]), 32'd0);
        k = 0;
        while (k < 20 && counter[3*W +: W] != 8'd10) begin step(); k++; end
        chk("ch3_at_10", 32'(counter[3*W +: W]), 32'd10);
        compare[3*W +: W] = 8'd5;
        k = 0;
        do begin step(); k++; end while (k < 300 && !match_pulse[3]);
        chk("ch3_wrap_latency", 32'(k), 32'd252);

        // asynchronous reset mid-count, then full-period restart
        one_shot = '0;
        clear = '1;
        step();
        clear = '0;
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge axi_clk) rst_n = 1'b1;
        repeat (3) step();
        chk("restart_no_early", 32'(match_pulse[0]), 32'd0);
        step();
        chk("restart_first_match", 32'(match_pulse[0]), 32'd1);

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < NC; n++) begin
                enable[n]    = ($urandom_range(0, 9) != 0);
                clear[n]     = ($urandom_range(0, 40) == 0);
                irq_clear[n] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 30) == 0) one_shot[n] = ~one_shot[n];
                if ($urandom_range(0, 50) == 0) prescaler[n*PW +: PW] = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 50) == 0) compare[n*W +: W] = 8'($urandom_range(0, 12));
            end
            irq_en = 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
